// File: rtl/cim_pkg.sv
// Shared types and width/requantization helpers for the CIM crossbar tile.
// Constant functions here size ports and accumulators in the tile and weight memory.
package cim_pkg;

  typedef enum logic [1:0] {IDLE, COMPUTE, DRAIN} tile_state_e;

  function automatic int acc_width(input int datatype_size, input int xbar_size);
    return 2 * datatype_size + $clog2(xbar_size);
  endfunction

  // Index width that never collapses to zero bits for single-entry dimensions.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [63:0] sat_trunc(input logic [63:0] acc, input int shift,
                                            input int out_w);
    logic [63:0] shifted;
    logic [63:0] max_val;
    shifted = acc >> shift;
    max_val = (64'd1 << out_w) - 64'd1;
    return (shifted > max_val) ? max_val : shifted;
  endfunction

endpackage

// File: rtl/cim_tile_if.sv
// Controller-facing port bundle of one CIM tile: buffer/weight writes, start/busy, result read.
// Master is the layer controller / activation stage, slave is the tile.
interface cim_tile_if
  import cim_pkg::*;
#(
  parameter int xbar_size     = 512,
  parameter int datatype_size = 8,
  parameter int n_cols        = xbar_size / datatype_size
);
  localparam int row_w = idx_width(xbar_size);
  localparam int col_w = idx_width(n_cols);

  logic                     i_we;
  logic [row_w-1:0]         i_wr_addr;
  logic [datatype_size-1:0] i_wr_data;
  logic                     i_w_we;
  logic [row_w-1:0]         i_w_row;
  logic [col_w-1:0]         i_w_col;
  logic [datatype_size-1:0] i_w_data;
  logic                     i_start;
  logic                     o_busy;
  logic [row_w-1:0]         i_rd_addr;
  logic [datatype_size-1:0] o_rd_data;

  modport master (
    output i_we, i_wr_addr, i_wr_data, i_w_we, i_w_row, i_w_col, i_w_data, i_start, i_rd_addr,
    input  o_busy, o_rd_data
  );

  modport slave (
    input  i_we, i_wr_addr, i_wr_data, i_w_we, i_w_row, i_w_col, i_w_data, i_start, i_rd_addr,
    output o_busy, o_rd_data
  );
endinterface

// File: rtl/cim_xbar_mem.sv
// Crossbar weight array: one word write port, one full-row read port with a registered address.
// Read data appears the cycle after rd_row is presented; no backpressure.
module cim_xbar_mem
  import cim_pkg::*;
#(
  parameter int xbar_size     = 512,
  parameter int datatype_size = 8,
  parameter int n_cols        = xbar_size / datatype_size
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   we,
  input  logic [idx_width(xbar_size)-1:0]        w_row,
  input  logic [idx_width(n_cols)-1:0]           w_col,
  input  logic [datatype_size-1:0]               w_data,
  input  logic [idx_width(xbar_size)-1:0]        rd_row,
  output logic [n_cols-1:0][datatype_size-1:0]   rd_data
);
  localparam int row_w = idx_width(xbar_size);

  logic [datatype_size-1:0] mem [xbar_size][n_cols];
  logic [row_w-1:0]         addr_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[w_row][w_col] <= w_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
    end else begin
      addr_q <= rd_row;
    end
  end

  // Combinational from the registered address, so a write on the same edge is visible.
  always_comb begin
    for (int c = 0; c < n_cols; c++) begin
      rd_data[c] = mem[addr_q][c];
    end
  end
endmodule

// File: rtl/cim_tile.sv
// One CIM crossbar tile: row-serial MAC over stored weights, xbar_size+1 busy cycles per run.
// Inputs are ignored while o_busy is high; result reads have one cycle of latency.
module cim_tile
  import cim_pkg::*;
#(
  parameter int xbar_size     = 512,
  parameter int datatype_size = 8,
  parameter int n_cols        = xbar_size / datatype_size,
  parameter int out_shift     = 0
) (
  input logic       clk,
  input logic       rst,
  cim_tile_if.slave bus
);
  localparam int row_w = idx_width(xbar_size);
  localparam int col_w = idx_width(n_cols);
  localparam int acc_w = acc_width(datatype_size, xbar_size);
  localparam logic [row_w-1:0] last_row = row_w'(xbar_size - 1);

  tile_state_e                          state_q, state_d;
  logic                                 busy_q;
  logic [row_w-1:0]                     row_q;
  logic [row_w-1:0]                     pf_row;
  logic                                 idle, start, w_we;
  logic [datatype_size-1:0]             ibuf [xbar_size];
  logic [acc_w-1:0]                     acc_q [n_cols];
  logic [datatype_size-1:0]             obuf_q [n_cols];
  logic [datatype_size-1:0]             obuf_d [n_cols];
  logic [n_cols-1:0][datatype_size-1:0] w_rd;
  logic [col_w-1:0]                     rd_col;
  logic [datatype_size-1:0]             rd_data_q;

  assign idle  = (state_q == IDLE);
  assign start = idle && bus.i_start;
  assign w_we  = idle && bus.i_w_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  // Weight row address runs one row ahead; the idle prefetch of row 0 overlaps the start cycle.
  always_comb begin
    state_d = state_q;
    pf_row  = '0;
    case (state_q)
      IDLE:    if (bus.i_start) state_d = COMPUTE;
      COMPUTE: begin
        pf_row = row_q + row_w'(1);
        if (row_q == last_row) state_d = DRAIN;
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (idle && bus.i_we) begin
      ibuf[bus.i_wr_addr] <= bus.i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      row_q <= '0;
      for (int c = 0; c < n_cols; c++) acc_q[c] <= '0;
    end else if (state_q == COMPUTE) begin
      row_q <= row_q + row_w'(1);
      for (int c = 0; c < n_cols; c++) begin
        acc_q[c] <= acc_q[c] + acc_w'(ibuf[row_q]) * acc_w'(w_rd[c]);
      end
    end
  end

  always_comb begin
    for (int c = 0; c < n_cols; c++) begin
      obuf_d[c] = (state_q == DRAIN)
                ? datatype_size'(sat_trunc(64'(acc_q[c]), out_shift, datatype_size))
                : obuf_q[c];
    end
  end

  assign rd_col = bus.i_rd_addr[col_w-1:0];

  // Read port sees the next obuf so fresh results show the first cycle busy is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < n_cols; c++) obuf_q[c] <= '0;
      rd_data_q <= '0;
    end else begin
      for (int c = 0; c < n_cols; c++) obuf_q[c] <= obuf_d[c];
      rd_data_q <= (32'(bus.i_rd_addr) < n_cols) ? obuf_d[rd_col] : '0;
    end
  end

  assign bus.o_busy    = busy_q;
  assign bus.o_rd_data = rd_data_q;

  cim_xbar_mem #(
    .xbar_size    (xbar_size),
    .datatype_size(datatype_size),
    .n_cols       (n_cols)
  ) u_xbar_mem (
    .clk    (clk),
    .rst    (rst),
    .we     (w_we),
    .w_row  (bus.i_w_row),
    .w_col  (bus.i_w_col),
    .w_data (bus.i_w_data),
    .rd_row (pf_row),
    .rd_data(w_rd)
  );
endmodule

// File: tb/tb_cim_tile.sv
// Bench for cim_tile: two tiles (out_shift 0 and 16) share stimulus and are checked
// against a dot-product reference model of the stored vector and weights.
module tb_cim_tile;
  localparam int xs = 8;
  localparam int dw = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  int          ib_m [xs];
  int          w_m  [xs];
  logic [31:0] prev0, prev1;

  cim_tile_if #(.xbar_size(xs), .datatype_size(dw)) bus0 ();
  cim_tile_if #(.xbar_size(xs), .datatype_size(dw)) bus1 ();

  assign bus1.i_we      = bus0.i_we;
  assign bus1.i_wr_addr = bus0.i_wr_addr;
  assign bus1.i_wr_data = bus0.i_wr_data;
  assign bus1.i_w_we    = bus0.i_w_we;
  assign bus1.i_w_row   = bus0.i_w_row;
  assign bus1.i_w_col   = bus0.i_w_col;
  assign bus1.i_w_data  = bus0.i_w_data;
  assign bus1.i_start   = bus0.i_start;
  assign bus1.i_rd_addr = bus0.i_rd_addr;

  cim_tile #(.xbar_size(xs), .datatype_size(dw), .out_shift(0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  cim_tile #(.xbar_size(xs), .datatype_size(dw), .out_shift(16)) u_dut16 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Dot product of the stored vector and weights, shifted then clamped to 8 bits.
  function automatic logic [31:0] ref_out(input int shift);
    longint unsigned s;
    s = 0;
    for (int r = 0; r < xs; r++) s += 64'(ib_m[r] * w_m[r]);
    s = s >> shift;
    return (s > 255) ? 32'd255 : 32'(s);
  endfunction

  // mode 0: ibuf 1..8, weights 2; 1: all 255; 2: weights 1; 3: random
  task automatic load(input int mode);
    for (int r = 0; r < xs; r++) begin
      case (mode)
        0: begin ib_m[r] = r + 1; w_m[r] = 2; end
        1: begin ib_m[r] = 255; w_m[r] = 255; end
        2: w_m[r] = 1;
        default: begin
          ib_m[r] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(200, 255))
                                                : int'($urandom_range(0, 255));
          w_m[r]  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(200, 255))
                                                : int'($urandom_range(0, 255));
        end
      endcase
      bus0.i_we      = 1'b1;
      bus0.i_wr_addr = 3'(r);
      bus0.i_wr_data = 8'(ib_m[r]);
      bus0.i_w_we    = 1'b1;
      bus0.i_w_row   = 3'(r);
      bus0.i_w_col   = '0;
      bus0.i_w_data  = 8'(w_m[r]);
      @(negedge clk);
    end
    bus0.i_we   = 1'b0;
    bus0.i_w_we = 1'b0;
  endtask

  task automatic read_chk();
    logic [2:0] a;
    for (int k = 0; k < 4; k++) begin
      a = (k == 0) ? 3'd0 : (k == 1) ? 3'd7 : 3'($urandom_range(1, 7));
      bus0.i_rd_addr = a;
      @(negedge clk);
      check("rd_addr_s0", 32'(bus0.o_rd_data), (a == 3'd0) ? prev0 : 32'd0);
      check("rd_addr_s16", 32'(bus1.o_rd_data), (a == 3'd0) ? prev1 : 32'd0);
    end
    bus0.i_rd_addr = 3'd0;
    @(negedge clk);
  endtask

  // mode 0: plain; 1: writes and start while busy; 2: reset on row 4; 3: write with start
  task automatic run(input int mode);
    int         cnt;
    int         wa;
    logic [7:0] wd;
    bus0.i_start = 1'b1;
    if (mode == 3) begin
      wa = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(0, xs - 1));
      wd = 8'($urandom_range(0, 255));
      bus0.i_we      = 1'b1;
      bus0.i_wr_addr = 3'(wa);
      bus0.i_wr_data = wd;
      ib_m[wa]       = int'(wd);
    end
    @(negedge clk);
    bus0.i_start = 1'b0;
    bus0.i_we    = 1'b0;
    check("busy_rise_s0", 32'(bus0.o_busy), 32'd1);
    check("busy_rise_s16", 32'(bus1.o_busy), 32'd1);
    cnt = 0;
    while (bus0.o_busy && cnt < 100) begin
      cnt++;
      check("rd_busy_s0", 32'(bus0.o_rd_data), prev0);
      check("rd_busy_s16", 32'(bus1.o_rd_data), prev1);
      if (mode == 1) begin
        bus0.i_we      = (cnt == 2);
        bus0.i_wr_addr = 3'd0;
        bus0.i_wr_data = 8'd99;
        bus0.i_w_we    = (cnt == 2);
        bus0.i_w_row   = 3'd0;
        bus0.i_w_data  = 8'd200;
        bus0.i_start   = (cnt == 4);
      end
      if (mode == 2 && cnt == 5) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy_s0", 32'(bus0.o_busy), 32'd0);
        check("abort_busy_s16", 32'(bus1.o_busy), 32'd0);
        check("abort_rd_s0", 32'(bus0.o_rd_data), 32'd0);
        check("abort_rd_s16", 32'(bus1.o_rd_data), 32'd0);
        prev0 = 32'd0;
        prev1 = 32'd0;
        return;
      end
      @(negedge clk);
    end
    check("busy_len", 32'(cnt), 32'(xs + 1));
    prev0 = ref_out(0);
    prev1 = ref_out(16);
    check("result_s0", 32'(bus0.o_rd_data), prev0);
    check("result_s16", 32'(bus1.o_rd_data), prev1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst            = 1'b1;
    bus0.i_we      = 1'b0;
    bus0.i_wr_addr = '0;
    bus0.i_wr_data = '0;
    bus0.i_w_we    = 1'b0;
    bus0.i_w_row   = '0;
    bus0.i_w_col   = '0;
    bus0.i_w_data  = '0;
    bus0.i_start   = 1'b0;
    bus0.i_rd_addr = '0;
    prev0          = 32'd0;
    prev1          = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus0.o_busy), 32'd0);
    check("rst_rd", 32'(bus0.o_rd_data), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    read_chk();

    load(0); run(0);
    check("basic_72", 32'(bus0.o_rd_data), 32'd72);
    read_chk();

    load(2); run(0);
    check("weights1_36", 32'(bus0.o_rd_data), 32'd36);

    load(1); run(0);
    check("sat_255", 32'(bus0.o_rd_data), 32'd255);
    check("sat_shift16_7", 32'(bus1.o_rd_data), 32'd7);

    load(0); run(1);
    check("guard_72", 32'(bus0.o_rd_data), 32'd72);
    run(0);
    check("guard_keep_72", 32'(bus0.o_rd_data), 32'd72);

    run(2); run(0);
    check("after_abort_72", 32'(bus0.o_rd_data), 32'd72);

    run(0); run(0); run(3);
    read_chk();

    repeat (8) begin
      load(3);
      run(($urandom_range(0, 1) == 1) ? 3 : 0);
      read_chk();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
